// File: rtl/l2_cacheline_adaptor.sv
// rtl/l2_cacheline_adaptor.sv - L2 line port to 4-beat 64-bit DRAM burst adaptor
// Every output is a flop, so nothing on the DRAM or L2 side is combinational from pmem_*.
module l2_cacheline_adaptor #(
   parameter int BEATS = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [31:0]  pmem_address,
   input  logic         pmem_read,
   input  logic         pmem_write,
   input  logic [255:0] pmem_wdata,
   output logic [255:0] pmem_rdata,
   output logic         pmem_resp,
   output logic [31:0]  dram_address,
   output logic         dram_read,
   output logic         dram_write,
   output logic [63:0]  dram_wdata,
   input  logic [63:0]  dram_rdata,
   input  logic         dram_resp
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [31:0]   addr_q, addr_d;
   logic [255:0]  wline_q, wline_d;
   logic [255:0]  rline_q, rline_d;
   logic          dram_read_q, dram_read_d;
   logic          dram_write_q, dram_write_d;
   logic          pmem_resp_q, pmem_resp_d;
   logic [63:0]   dram_wdata_q, dram_wdata_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wline_d = wline_q;
      rline_d = rline_q;
      case (state_q)
         IDLE: begin
            if (pmem_read) begin
               addr_d  = {pmem_address[31:5], 5'b0};
               cnt_d   = 2'd0;
               state_d = READ;
            end else if (pmem_write) begin
               addr_d  = {pmem_address[31:5], 5'b0};
               wline_d = pmem_wdata;
               cnt_d   = 2'd0;
               state_d = WRITE;
            end
         end
         READ: begin
            if (dram_resp) begin
               rline_d[{cnt_q, 6'b0} +: 64] = dram_rdata;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'(BEATS - 1)) state_d = RESP;
            end
         end
         WRITE: begin
            if (dram_resp) begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'(BEATS - 1)) state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are precomputed from the next state so they appear registered one cycle later.
      dram_read_d  = (state_d == READ);
      dram_write_d = (state_d == WRITE);
      pmem_resp_d  = (state_d == RESP);
      dram_wdata_d = (state_d == WRITE) ? wline_d[{cnt_d, 6'b0} +: 64] : 64'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= 2'd0;
         addr_q       <= 32'd0;
         wline_q      <= 256'd0;
         rline_q      <= 256'd0;
         dram_read_q  <= 1'b0;
         dram_write_q <= 1'b0;
         pmem_resp_q  <= 1'b0;
         dram_wdata_q <= 64'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         wline_q      <= wline_d;
         rline_q      <= rline_d;
         dram_read_q  <= dram_read_d;
         dram_write_q <= dram_write_d;
         pmem_resp_q  <= pmem_resp_d;
         dram_wdata_q <= dram_wdata_d;
      end
   end

   assign pmem_rdata   = rline_q;
   assign pmem_resp    = pmem_resp_q;
   assign dram_address = addr_q;
   assign dram_read    = dram_read_q;
   assign dram_write   = dram_write_q;
   assign dram_wdata   = dram_wdata_q;

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// tb/tb_l2_cacheline_adaptor.sv - directed bench for l2_cacheline_adaptor
module tb_l2_cacheline_adaptor;

   logic         clk;
   logic         rst_n;
   logic [31:0]  pmem_address;
   logic         pmem_read;
   logic         pmem_write;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;
   logic [31:0]  dram_address;
   logic         dram_read;
   logic         dram_write;
   logic [63:0]  dram_wdata;
   logic [63:0]  dram_rdata;
   logic         dram_resp;

   l2_cacheline_adaptor #(.BEATS(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pmem_address (pmem_address),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp),
      .dram_address (dram_address),
      .dram_read    (dram_read),
      .dram_write   (dram_write),
      .dram_wdata   (dram_wdata),
      .dram_rdata   (dram_rdata),
      .dram_resp    (dram_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         rd;
      logic         wr;
      logic [31:0]  addr;
      logic [255:0] wline;
      logic         resp;
      logic [63:0]  rdata;
      logic         e_dr;
      logic         e_dw;
      logic         e_pr;
      logic [31:0]  e_addr;
      logic [63:0]  e_wdata;
      logic [255:0] e_rline;
   } vec_t;

   int tests_run = 0;
   int tests_failed = 0;

   function automatic vec_t mk(logic rd, logic wr, logic [31:0] addr, logic [255:0] wline,
                               logic resp, logic [63:0] rdata, logic e_dr, logic e_dw,
                               logic e_pr, logic [31:0] e_addr, logic [63:0] e_wdata,
                               logic [255:0] e_rline);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = addr; v.wline = wline; v.resp = resp; v.rdata = rdata;
      v.e_dr = e_dr; v.e_dw = e_dw; v.e_pr = e_pr; v.e_addr = e_addr;
      v.e_wdata = e_wdata; v.e_rline = e_rline;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [359:0] act, input logic [359:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [359:0] outs();
      return 360'({dram_read, dram_write, pmem_resp, dram_address, dram_wdata, pmem_rdata});
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Drive a read and feed beats while dram_read is up; optional every-other-cycle stalls.
   task automatic run_read(input logic [31:0] a, input logic [7:0] seed, input bit stall,
                           output int ns, output logic [255:0] line);
      int n;
      ns = 0;
      n = 0;
      line = '0;
      pmem_address = a;
      pmem_read = 1'b1;
      dram_resp = 1'b0;
      cyc();
      while (!pmem_resp && n < 40) begin
         dram_resp  = dram_read && (!stall || (n % 2 == 1));
         dram_rdata = {8{seed + 8'(ns)}};
         if (dram_resp) begin
            if (ns < 4) line[ns*64 +: 64] = dram_rdata;
            ns++;
         end
         cyc();
         n++;
      end
      pmem_read = 1'b0;
      dram_resp = 1'b0;
   endtask

   localparam logic [63:0] R1 = 64'h1111_1111_1111_1111;
   localparam logic [63:0] R2 = 64'h2222_2222_2222_2222;
   localparam logic [63:0] R3 = 64'h3333_3333_3333_3333;
   localparam logic [63:0] R4 = 64'h4444_4444_4444_4444;
   localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
   localparam logic [63:0] D2 = 64'hA5A5_A5A5_5A5A_5A5A;
   localparam logic [63:0] D3 = 64'h0F0F_F0F0_1234_8765;
   localparam logic [31:0] A  = 32'h0000_1234;
   localparam logic [31:0] AX = 32'hFFFF_FFFF;
   localparam logic [31:0] AR = 32'h0000_1220;
   localparam logic [31:0] WA = 32'hABCD_EF7F;
   localparam logic [31:0] AW = 32'hABCD_EF60;

   vec_t vecs[18];

   initial begin
      logic [255:0] l1, wl, p1, p2, p3, line, l_before;
      int ns;

      l1 = {R4, R3, R2, R1};
      wl = {D3, D2, D1, D0};
      p1 = {192'd0, R1};
      p2 = {128'd0, R2, R1};
      p3 = {64'd0, R3, R2, R1};

      // zero-wait read; address changes after acceptance must not matter
      vecs[0]  = mk(1, 0, A,  '0, 0, '0, 0, 0, 0, 32'd0, '0, '0);
      vecs[1]  = mk(1, 0, AX, '0, 1, R1, 1, 0, 0, AR, '0, '0);
      vecs[2]  = mk(1, 0, AX, '0, 1, R2, 1, 0, 0, AR, '0, p1);
      vecs[3]  = mk(1, 0, AX, '0, 1, R3, 1, 0, 0, AR, '0, p2);
      vecs[4]  = mk(1, 0, AX, '0, 1, R4, 1, 0, 0, AR, '0, p3);
      vecs[5]  = mk(1, 0, AX, '0, 0, '0, 0, 0, 1, AR, '0, l1);
      vecs[6]  = mk(0, 0, A,  '0, 0, '0, 0, 0, 0, AR, '0, l1);
      // back-to-back stalled write; wdata changes after acceptance must not matter
      vecs[7]  = mk(0, 1, WA, wl, 0, '0, 0, 0, 0, AR, '0, l1);
      vecs[8]  = mk(0, 1, AX, '0, 1, '0, 0, 1, 0, AW, D0, l1);
      vecs[9]  = mk(0, 1, AX, '0, 0, '0, 0, 1, 0, AW, D1, l1);
      vecs[10] = mk(0, 1, AX, '0, 0, '0, 0, 1, 0, AW, D1, l1);
      vecs[11] = mk(0, 1, AX, '0, 1, '0, 0, 1, 0, AW, D1, l1);
      vecs[12] = mk(0, 1, AX, '0, 1, '0, 0, 1, 0, AW, D2, l1);
      vecs[13] = mk(0, 1, AX, '0, 0, '0, 0, 1, 0, AW, D3, l1);
      vecs[14] = mk(0, 1, AX, '0, 1, '0, 0, 1, 0, AW, D3, l1);
      vecs[15] = mk(0, 1, AX, '0, 0, '0, 0, 0, 1, AW, '0, l1);
      vecs[16] = mk(0, 0, AX, '0, 0, '0, 0, 0, 0, AW, '0, l1);
      vecs[17] = mk(0, 0, AX, '0, 0, '0, 0, 0, 0, AW, '0, l1);

      rst_n = 1'b0;
      pmem_address = '0;
      pmem_read = 1'b0;
      pmem_write = 1'b0;
      pmem_wdata = '0;
      dram_rdata = '0;
      dram_resp = 1'b0;
      #1;
      chk("reset_async", outs(), '0);
      for (int i = 0; i < 3; i++) cyc();
      chk("reset_held", outs(), '0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk($sformatf("idle%0d", i), outs(), '0);
      end

      for (int i = 0; i < 18; i++) begin
         pmem_read    = vecs[i].rd;
         pmem_write   = vecs[i].wr;
         pmem_address = vecs[i].addr;
         pmem_wdata   = vecs[i].wline;
         dram_resp    = vecs[i].resp;
         dram_rdata   = vecs[i].rdata;
         chk($sformatf("vec%0d", i), outs(),
             360'({vecs[i].e_dr, vecs[i].e_dw, vecs[i].e_pr, vecs[i].e_addr,
                   vecs[i].e_wdata, vecs[i].e_rline}));
         cyc();
      end

      // stray strobes in IDLE
      l_before = l1;
      dram_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         dram_resp = 1'b1;
         cyc();
         chk($sformatf("stray%0d", i), 360'({pmem_resp, dram_read, pmem_rdata}),
             360'({1'b0, 1'b0, l_before}));
      end
      dram_resp = 1'b0;
      run_read(32'h2000_0047, 8'h50, 1'b0, ns, line);
      chk("stray_read_beats", 360'(ns), 360'(4));
      chk("stray_read_resp", 360'(pmem_resp), 360'(1));
      chk("stray_read_line", 360'({dram_address, pmem_rdata}), 360'({32'h2000_0040, line}));
      cyc();
      chk("stray_read_pulse", 360'({pmem_resp, dram_read}), 360'(0));

      // reset after beat 2 of a read
      pmem_address = 32'h3000_0000;
      pmem_read = 1'b1;
      cyc();
      dram_resp = 1'b1;
      dram_rdata = 64'hCAFE_CAFE_CAFE_CAFE;
      cyc();
      cyc();
      rst_n = 1'b0;
      #1;
      chk("midreset_async", outs(), '0);
      dram_resp = 1'b0;
      pmem_read = 1'b0;
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk($sformatf("midreset_quiet%0d", i), 360'({pmem_resp, dram_read, dram_write}), 360'(0));
      end
      run_read(32'h4000_001F, 8'hA0, 1'b1, ns, line);
      chk("fresh_read_beats", 360'(ns), 360'(4));
      chk("fresh_read_resp", 360'(pmem_resp), 360'(1));
      chk("fresh_read_line", 360'({dram_address, pmem_rdata}), 360'({32'h4000_0000, line}));
      cyc();
      chk("fresh_read_pulse", 360'({pmem_resp, dram_read}), 360'(0));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
